// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the round-robin arbiter.
package rr_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int PERF_W = 16;

endpackage

// File: rtl/maske.sv
// Encoded-index to thermometer mask generator; selectable inclusive/exclusive and left/right.
module maske #(
  parameter int  W              = 4,
  parameter bit  P_INCLUSIVE    = 1'b0,
  parameter bit  LEFT_NOT_RIGHT = 1'b1,
  localparam int IDX_W          = $clog2(W)
) (
  input  logic [IDX_W-1:0] idx,
  output logic [W-1:0]     mask
);

  always_comb begin
    mask = '0;
    for (int i = 0; i < W; i++) begin
      if (LEFT_NOT_RIGHT)
        mask[i] = P_INCLUSIVE ? (i >= int'(idx)) : (i > int'(idx));
      else
        mask[i] = P_INCLUSIVE ? (i <= int'(idx)) : (i < int'(idx));
    end
  end

endmodule

// File: rtl/pri_lsb.sv
// Lowest-set-bit finder: one-hot, encoded index and any-set outputs.
module pri_lsb #(
  parameter int  W     = 4,
  localparam int IDX_W = $clog2(W)
) (
  input  logic [W-1:0]     vec,
  output logic [W-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = |vec;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/rr_arb.sv
// Round-robin arbiter with grant held until ack; RR_ARB_PERF_EN adds a saturating stall counter.
//
// state | meaning
// IDLE  | no grant presented, waiting for any request
// BUSY  | grant presented and locked until ack_i
module rr_arb
  import rr_arb_pkg::*;
#(
  parameter int  W     = 4,
  localparam int IDX_W = $clog2(W)
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [W-1:0]     req_i,
  input  logic             ack_i,
  output logic             valid_o,
  output logic [W-1:0]     grant_o,
  output logic [IDX_W-1:0] grant_idx_o
`ifdef RR_ARB_PERF_EN
  ,
  output logic [PERF_W-1:0] stall_cnt_o
`endif
);

  state_t           state;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] mask_idx;
  logic [W-1:0]     mask;
  logic [W-1:0]     hi;
  logic [W-1:0]     hi_oh;
  logic [W-1:0]     all_oh;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] all_idx;
  logic             hi_any;
  logic             all_any;
  logic [W-1:0]     win_oh;
  logic [IDX_W-1:0] win_idx;

  // On an accepted grant the pointer update and the next arbitration share
  // one cycle, so arbitrate against the grant being retired, not ptr_q.
  assign mask_idx = (state == BUSY) ? grant_idx_o : ptr_q;

  maske #(
    .W              (W),
    .P_INCLUSIVE    (1'b0),
    .LEFT_NOT_RIGHT (1'b1)
  ) u_mask (
    .idx  (mask_idx),
    .mask (mask)
  );

  assign hi = req_i & mask;

  pri_lsb #(.W(W)) u_pri_hi (
    .vec    (hi),
    .onehot (hi_oh),
    .idx    (hi_idx),
    .any    (hi_any)
  );

  pri_lsb #(.W(W)) u_pri_all (
    .vec    (req_i),
    .onehot (all_oh),
    .idx    (all_idx),
    .any    (all_any)
  );

  assign win_oh  = hi_any ? hi_oh  : all_oh;
  assign win_idx = hi_any ? hi_idx : all_idx;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state       <= IDLE;
      ptr_q       <= IDX_W'(W - 1);
      valid_o     <= 1'b0;
      grant_o     <= '0;
      grant_idx_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (all_any) begin
            valid_o     <= 1'b1;
            grant_o     <= win_oh;
            grant_idx_o <= win_idx;
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (ack_i) begin
            ptr_q <= grant_idx_o;
            if (all_any) begin
              grant_o     <= win_oh;
              grant_idx_o <= win_idx;
            end else begin
              valid_o     <= 1'b0;
              grant_o     <= '0;
              grant_idx_o <= '0;
              state       <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RR_ARB_PERF_EN
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)
      stall_cnt_o <= '0;
    else if (valid_o && !ack_i && (stall_cnt_o != '1))
      stall_cnt_o <= stall_cnt_o + PERF_W'(1);
  end
`endif

endmodule
